// File: rtl/tile_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tile_frame_scheduler
//  Description : Walks a MAP_W x MAP_H tile map row-major, looks up each
//                cell's tile index in a synchronous map RAM and hands the
//                ROM address and pixel origin to a single tile drawer.
//                A one-entry cell-update buffer is served between tiles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tile_frame_scheduler #(
  parameter int MAP_W     = 20,
  parameter int MAP_H     = 15,
  parameter int NUM_TILES = 21,
  parameter int TIMEOUT   = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  input  logic        cell_req,
  input  logic [4:0]  cell_x,
  input  logic [3:0]  cell_y,
  output logic        cell_ready,
  output logic [8:0]  map_rd_addr,
  input  logic [4:0]  map_rd_data,
  output logic [11:0] tile_address,
  output logic [7:0]  x_pos,
  output logic [7:0]  y_pos,
  output logic        draw,
  input  logic        drawer_active,
  output logic        err_tile,
  output logic        err_timeout
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_MAP_RD     = 3'd1,
    S_MAP_WAIT   = 3'd2,
    S_ISSUE      = 3'd3,
    S_WAIT_START = 3'd4,
    S_WAIT_DONE  = 3'd5,
    S_ADVANCE    = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      fx_q;
  logic [3:0]      fy_q;
  logic            busy_q;
  logic            frame_done_q;
  logic            cell_vld_q;
  logic [4:0]      cx_buf_q;
  logic [3:0]      cy_buf_q;
  logic            sel_cell_q;
  logic [4:0]      cur_x_q;
  logic [3:0]      cur_y_q;
  logic [8:0]      addr_q;
  logic [11:0]     tile_addr_q;
  logic [7:0]      x_pos_q;
  logic [7:0]      y_pos_q;
  logic            err_tile_q;
  logic            err_tmo_q;
  logic [TW-1:0]   tmo_cnt_q;

  // Selected cell for the next tile: a pending cell update wins over the frame walk.
  logic [4:0] w_sel_x;
  logic [3:0] w_sel_y;
  logic       w_idx_bad;
  logic [4:0] w_idx;
  logic       w_tmo_hit;
  logic       w_cell_in_range;
  logic       w_last_col;
  logic       w_last_row;

  assign w_sel_x         = cell_vld_q ? cx_buf_q : fx_q;
  assign w_sel_y         = cell_vld_q ? cy_buf_q : fy_q;
  assign w_idx_bad       = (map_rd_data >= 5'(NUM_TILES));
  assign w_idx           = w_idx_bad ? 5'd0 : map_rd_data;
  assign w_tmo_hit       = (tmo_cnt_q == TW'(TIMEOUT - 1));
  assign w_cell_in_range = (cell_x < 5'(MAP_W)) && (cell_y < 4'(MAP_H));
  assign w_last_col      = (fx_q == 5'(MAP_W - 1));
  assign w_last_row      = (fy_q == 4'(MAP_H - 1));

  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign cell_ready   = ~cell_vld_q;
  assign map_rd_addr  = addr_q;
  assign tile_address = tile_addr_q;
  assign x_pos        = x_pos_q;
  assign y_pos        = y_pos_q;
  assign err_tile     = err_tile_q;
  assign err_timeout  = err_tmo_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode and the one-cycle draw strobe.
  always_comb begin
    state_d = state_q;
    draw    = 1'b0;
    case (state_q)
      S_IDLE:       if (cell_vld_q || busy_q) state_d = S_MAP_RD;
      S_MAP_RD:     state_d = S_MAP_WAIT;
      S_MAP_WAIT:   state_d = S_ISSUE;
      S_ISSUE: begin
        draw    = 1'b1;
        state_d = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (drawer_active)  state_d = S_WAIT_DONE;
        else if (w_tmo_hit) state_d = S_ADVANCE;
      end
      S_WAIT_DONE:  if (!drawer_active) state_d = S_ADVANCE;
      S_ADVANCE:    state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Datapath: cell buffer, frame counters, tile parameters, timeout and error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      fx_q         <= '0;
      fy_q         <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      cell_vld_q   <= 1'b0;
      cx_buf_q     <= '0;
      cy_buf_q     <= '0;
      sel_cell_q   <= 1'b0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      addr_q       <= '0;
      tile_addr_q  <= '0;
      x_pos_q      <= '0;
      y_pos_q      <= '0;
      err_tile_q   <= 1'b0;
      err_tmo_q    <= 1'b0;
      tmo_cnt_q    <= '0;
    end else begin
      frame_done_q <= 1'b0;

      // Out-of-range requests are acknowledged but never occupy the buffer.
      if (cell_req && !cell_vld_q && w_cell_in_range) begin
        cell_vld_q <= 1'b1;
        cx_buf_q   <= cell_x;
        cy_buf_q   <= cell_y;
      end

      if (state_q == S_IDLE && start && !busy_q) begin
        busy_q <= 1'b1;
        fx_q   <= '0;
        fy_q   <= '0;
      end

      case (state_q)
        S_IDLE: begin
          if (cell_vld_q || busy_q) begin
            sel_cell_q <= cell_vld_q;
            cur_x_q    <= w_sel_x;
            cur_y_q    <= w_sel_y;
            addr_q     <= 9'(w_sel_y) * 9'(MAP_W) + 9'(w_sel_x);
          end
        end
        S_MAP_WAIT: begin
          if (w_idx_bad) err_tile_q <= 1'b1;
          tile_addr_q <= {w_idx, 7'b0} + {1'b0, w_idx, 6'b0};
          x_pos_q     <= {cur_x_q, 3'b0};
          y_pos_q     <= {1'b0, cur_y_q, 3'b0};
        end
        S_ISSUE: tmo_cnt_q <= '0;
        S_WAIT_START: begin
          if (!drawer_active) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
            if (w_tmo_hit) err_tmo_q <= 1'b1;
          end
        end
        S_ADVANCE: begin
          if (sel_cell_q) begin
            cell_vld_q <= 1'b0;
          end else if (w_last_col) begin
            fx_q <= '0;
            if (w_last_row) begin
              fy_q         <= '0;
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
            end else begin
              fy_q <= fy_q + 1'b1;
            end
          end else begin
            fx_q <= fx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tile_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tile_frame_scheduler
//  Description : Scoreboard bench for tile_frame_scheduler with a map RAM
//                model and a tile drawer model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tile_frame_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        frame_done;
  logic        cell_req;
  logic [4:0]  cell_x;
  logic [3:0]  cell_y;
  logic        cell_ready;
  logic [8:0]  map_rd_addr;
  logic [4:0]  map_rd_data;
  logic [11:0] tile_address;
  logic [7:0]  x_pos;
  logic [7:0]  y_pos;
  logic        draw;
  logic        drawer_active;
  logic        err_tile;
  logic        err_timeout;

  always #5 clk = ~clk;

  tile_frame_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .frame_done   (frame_done),
    .cell_req     (cell_req),
    .cell_x       (cell_x),
    .cell_y       (cell_y),
    .cell_ready   (cell_ready),
    .map_rd_addr  (map_rd_addr),
    .map_rd_data  (map_rd_data),
    .tile_address (tile_address),
    .x_pos        (x_pos),
    .y_pos        (y_pos),
    .draw         (draw),
    .drawer_active(drawer_active),
    .err_tile     (err_tile),
    .err_timeout  (err_timeout)
  );

  // Synchronous map RAM.
  logic [4:0] map_mem [0:511];
  always @(posedge clk) map_rd_data <= map_mem[map_rd_addr];

  // Drawer: active for 10 cycles starting the cycle after draw, unless muted.
  int   dcnt = 0;
  logic no_resp = 1'b0;
  always @(posedge clk) begin
    if (draw && !no_resp) dcnt <= 10;
    else if (dcnt > 0)    dcnt <= dcnt - 1;
  end
  assign drawer_active = (dcnt != 0);

  int n_checks = 0;
  int n_err    = 0;
  int n_draw   = 0;
  int n_fd     = 0;
  logic [36:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected {map_rd_addr, x_pos, y_pos, tile_address} for cell (x,y).
  function automatic logic [36:0] exp_tile(input int x, input int y);
    int a;
    int idx;
    a   = y * 20 + x;
    idx = int'(map_mem[a]);
    if (idx >= 21) idx = 0;
    return {9'(a), 8'(x * 8), 8'(y * 8), 12'(idx * 192)};
  endfunction

  task automatic push_frame(input int from, input int to);
    for (int i = from; i <= to; i++) exp_q.push_back(exp_tile(i % 20, i / 20));
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (draw) begin
      n_draw++;
      if (exp_q.size() == 0) check("unexpected_draw", 64'(n_draw), 64'(0));
      else check("draw", {27'b0, map_rd_addr, x_pos, y_pos, tile_address}, {27'b0, exp_q.pop_front()});
    end
    if (frame_done) n_fd++;
  end

  task automatic wait_draws(input int target, input int budget);
    int c;
    c = 0;
    while (n_draw < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("wait_draws", 64'(n_draw), 64'(target));
  endtask

  task automatic wait_fd(input int target, input int budget);
    int c;
    c = 0;
    while (n_fd < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("wait_frame_done", 64'(n_fd), 64'(target));
  endtask

  task automatic wait_ready(input int budget);
    int c;
    c = 0;
    while (!cell_ready && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("cell_ready_rerise", 64'(cell_ready), 64'(1));
  endtask

  task automatic send_cell(input int x, input int y);
    cell_req = 1'b1;
    cell_x   = 5'(x);
    cell_y   = 4'(y);
    @(negedge clk);
    cell_req = 1'b0;
  endtask

  initial begin
    int d0;
    reset    = 1'b1;
    start    = 1'b0;
    cell_req = 1'b0;
    cell_x   = '0;
    cell_y   = '0;
    for (int i = 0; i < 512; i++) map_mem[i] = 5'(i % 21);
    map_mem[43] = 5'd20;
    map_mem[50] = 5'd25;

    repeat (3) @(negedge clk);
    check("rst_busy",        64'(busy),         64'(0));
    check("rst_cell_ready",  64'(cell_ready),   64'(1));
    check("rst_draw",        64'(draw),         64'(0));
    check("rst_frame_done",  64'(frame_done),   64'(0));
    check("rst_err_tile",    64'(err_tile),     64'(0));
    check("rst_err_timeout", 64'(err_timeout),  64'(0));
    check("rst_tile_addr",   64'(tile_address), 64'(0));
    check("rst_map_addr",    64'(map_rd_addr),  64'(0));
    reset = 1'b0;
    @(negedge clk);

    // Full frame with a cell update inserted after the 101st tile.
    push_frame(0, 100);
    exp_q.push_back(exp_tile(5, 5));
    push_frame(101, 299);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'(1));
    wait_draws(50, 3000);
    check("err_tile_before_bad", 64'(err_tile), 64'(0));
    wait_draws(101, 3000);
    check("err_tile_sticky", 64'(err_tile), 64'(1));
    repeat (3) @(negedge clk);
    check("cell_ready_idle", 64'(cell_ready), 64'(1));
    send_cell(5, 5);
    check("cell_ready_drop", 64'(cell_ready), 64'(0));
    wait_draws(102, 100);
    wait_ready(100);
    wait_fd(1, 8000);
    check("busy_at_frame_done", 64'(busy), 64'(0));
    check("frame_queue_empty", 64'(exp_q.size()), 64'(0));
    check("frame_draw_count", 64'(n_draw), 64'(301));
    repeat (5) @(negedge clk);
    check("frame_done_single", 64'(n_fd), 64'(1));
    check("err_timeout_clean", 64'(err_timeout), 64'(0));

    // Out-of-range cell request is swallowed without a draw.
    d0 = n_draw;
    send_cell(25, 3);
    check("oor_ready", 64'(cell_ready), 64'(1));
    repeat (20) @(negedge clk);
    check("oor_no_draw", 64'(n_draw), 64'(d0));

    // Silent drawer: timeout on a single cell draw at (3,2).
    no_resp = 1'b1;
    exp_q.push_back(exp_tile(3, 2));
    send_cell(3, 2);
    wait_draws(d0 + 1, 50);
    check("tmo_addr",  64'(tile_address), 64'(3840));
    check("tmo_x_pos", 64'(x_pos),        64'(24));
    check("tmo_y_pos", 64'(y_pos),        64'(16));
    check("tmo_map",   64'(map_rd_addr),  64'(43));
    repeat (6) @(negedge clk);
    check("tmo_not_yet", 64'(err_timeout), 64'(0));
    repeat (2) @(negedge clk);
    check("tmo_set", 64'(err_timeout), 64'(1));
    wait_ready(20);

    // Full frame with a silent drawer still completes.
    push_frame(0, 299);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_fd(2, 8000);
    check("tmo_frame_queue_empty", 64'(exp_q.size()), 64'(0));
    check("tmo_sticky", 64'(err_timeout), 64'(1));

    // Reset in the middle of a tile.
    no_resp = 1'b0;
    repeat (3) @(negedge clk);
    d0 = n_draw;
    push_frame(0, 299);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_draws(d0 + 5, 500);
    repeat (4) @(negedge clk);
    check("mid_drawer_active", 64'(drawer_active), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    check("mid_rst_busy",        64'(busy),        64'(0));
    check("mid_rst_ready",       64'(cell_ready),  64'(1));
    check("mid_rst_err_tile",    64'(err_tile),    64'(0));
    check("mid_rst_err_timeout", 64'(err_timeout), 64'(0));
    d0 = n_draw;
    repeat (40) @(negedge clk);
    check("mid_rst_no_draw", 64'(n_draw), 64'(d0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
